// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong match sequencer: score, serve timing, game_state; optional pause via PONG_PAUSE_EN
module pong_game_ctrl #(
  parameter int WIN_SCORE      = 5,
  parameter int SERVE_DELAY_MS = 1000,
  parameter int WIN_HOLD_MS    = 3000,
  parameter int CNT_W          = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1ms,
  input  logic       start,
  input  logic       miss_left,
  input  logic       miss_right,
`ifdef PONG_PAUSE_EN
  input  logic       pause,
`endif
  output logic [1:0] game_state,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       ball_enable,
  output logic       ball_reset,
  output logic       serve_dir
);

  localparam logic [CNT_W-1:0] SERVE_CNT = CNT_W'(SERVE_DELAY_MS);
  localparam logic [CNT_W-1:0] HOLD_CNT  = CNT_W'(WIN_HOLD_MS);
  localparam logic [3:0]       WIN_PTS   = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVE,
    S_PLAY,
    S_WIN1,
    S_WIN2
`ifdef PONG_PAUSE_EN
    , S_PAUSED
`endif
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]       score1_n, score2_n;
  logic             serve_dir_n;
  logic             start_q;
  logic             start_edge;
  logic [1:0]       game_state_n;
  logic             ball_enable_n, ball_reset_n;

  assign start_edge = start & ~start_q;
  assign cnt_inc    = cnt + CNT_W'(1);

`ifdef PONG_PAUSE_EN
  logic pause_q;
  logic pause_edge;
  assign pause_edge = pause & ~pause_q;

  // pause edge detector history, cleared by reset like start_q
  always_ff @(posedge clk) begin
    if (!reset) pause_q <= 1'b0;
    else        pause_q <= pause;
  end
`endif

  // state, counter, scores and edge-detector history
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      score1    <= 4'd0;
      score2    <= 4'd0;
      serve_dir <= 1'b1;
      start_q   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      score1    <= score1_n;
      score2    <= score2_n;
      serve_dir <= serve_dir_n;
      start_q   <= start;
    end
  end

  // next state: scoring, serve/win timing; counter restarts on every state change
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    score1_n    = score1;
    score2_n    = score2;
    serve_dir_n = serve_dir;
    case (state)
      S_IDLE: begin
        if (start_edge) begin
          state_n     = S_SERVE;
          score1_n    = 4'd0;
          score2_n    = 4'd0;
          serve_dir_n = 1'b1;
        end
      end
      S_SERVE: begin
        if (tick_1ms) begin
          if (cnt_inc == SERVE_CNT) state_n = S_PLAY;
          else                      cnt_n   = cnt_inc;
        end
      end
      S_PLAY: begin
        // miss_left has priority when both paddles report a miss together
        if (miss_left) begin
          score2_n = score2 + 4'd1;
          if (score2_n == WIN_PTS) begin
            state_n = S_WIN2;
          end else begin
            state_n     = S_SERVE;
            serve_dir_n = 1'b0;
          end
        end else if (miss_right) begin
          score1_n = score1 + 4'd1;
          if (score1_n == WIN_PTS) begin
            state_n = S_WIN1;
          end else begin
            state_n     = S_SERVE;
            serve_dir_n = 1'b1;
          end
        end
`ifdef PONG_PAUSE_EN
        else if (pause_edge) begin
          state_n = S_PAUSED;
        end
`endif
      end
      S_WIN1, S_WIN2: begin
        if (tick_1ms) begin
          if (cnt_inc == HOLD_CNT) state_n = S_IDLE;
          else                     cnt_n   = cnt_inc;
        end
      end
`ifdef PONG_PAUSE_EN
      S_PAUSED: begin
        if (pause_edge) state_n = S_PLAY;
      end
`endif
      default: state_n = S_IDLE;
    endcase
    if (state_n != state) cnt_n = '0;
  end

  // output decode of the upcoming state so outputs update on the triggering edge
  always_comb begin
    game_state_n  = 2'b00;
    ball_enable_n = 1'b0;
    ball_reset_n  = 1'b1;
    case (state_n)
      S_IDLE:  game_state_n = 2'b00;
      S_SERVE: game_state_n = 2'b01;
      S_PLAY: begin
        game_state_n  = 2'b01;
        ball_enable_n = 1'b1;
        ball_reset_n  = 1'b0;
      end
      S_WIN1:  game_state_n = 2'b10;
      S_WIN2:  game_state_n = 2'b11;
`ifdef PONG_PAUSE_EN
      S_PAUSED: begin
        game_state_n = 2'b01;
        ball_reset_n = 1'b0;
      end
`endif
      default: game_state_n = 2'b00;
    endcase
  end

  // registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      game_state  <= 2'b00;
      ball_enable <= 1'b0;
      ball_reset  <= 1'b1;
    end else begin
      game_state  <= game_state_n;
      ball_enable <= ball_enable_n;
      ball_reset  <= ball_reset_n;
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - directed and randomized checks of pong_game_ctrl against a match-level model
module tb_pong_game_ctrl;

  localparam int WS = 2;
  localparam int SD = 4;
  localparam int WH = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_1ms = 1'b0;
  logic       start = 1'b0;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] game_state;
  logic [3:0] score1, score2;
  logic       ball_enable, ball_reset, serve_dir;

  int total = 0;
  int bad = 0;

  pong_game_ctrl #(
    .WIN_SCORE(WS), .SERVE_DELAY_MS(SD), .WIN_HOLD_MS(WH), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .tick_1ms(tick_1ms), .start(start),
    .miss_left(miss_left), .miss_right(miss_right),
`ifdef PONG_PAUSE_EN
    .pause(pause),
`endif
    .game_state(game_state), .score1(score1), .score2(score2),
    .ball_enable(ball_enable), .ball_reset(ball_reset), .serve_dir(serve_dir)
  );

  always #5 clk = ~clk;

  // match-level model: phase name, points, direction, ticks still to wait
  string m_phase = "idle";
  int    m_p1 = 0, m_p2 = 0, m_dir = 1, m_wait = 0;
  bit    m_start_prev = 0, m_pause_prev = 0;

  task automatic model_step();
    bit st_rise, ps_rise;
    if (!reset) begin
      m_phase = "idle"; m_p1 = 0; m_p2 = 0; m_dir = 1; m_wait = 0;
      m_start_prev = 0; m_pause_prev = 0;
      return;
    end
    st_rise = start && !m_start_prev;
    ps_rise = pause && !m_pause_prev;
    m_start_prev = start;
    m_pause_prev = pause;
`ifndef PONG_PAUSE_EN
    ps_rise = 0;
`endif
    if (m_phase == "idle") begin
      if (st_rise) begin m_p1 = 0; m_p2 = 0; m_dir = 1; m_phase = "serve"; m_wait = SD; end
    end else if (m_phase == "serve") begin
      if (tick_1ms) begin m_wait--; if (m_wait == 0) m_phase = "play"; end
    end else if (m_phase == "play") begin
      if (miss_left) begin
        m_p2++;
        if (m_p2 == WS) begin m_phase = "p2win"; m_wait = WH; end
        else begin m_phase = "serve"; m_wait = SD; m_dir = 0; end
      end else if (miss_right) begin
        m_p1++;
        if (m_p1 == WS) begin m_phase = "p1win"; m_wait = WH; end
        else begin m_phase = "serve"; m_wait = SD; m_dir = 1; end
      end else if (ps_rise) m_phase = "paused";
    end else if (m_phase == "p1win" || m_phase == "p2win") begin
      if (tick_1ms) begin m_wait--; if (m_wait == 0) m_phase = "idle"; end
    end else if (m_phase == "paused") begin
      if (ps_rise) m_phase = "play";
    end
  endtask

  function automatic logic [12:0] model_vec();
    logic [1:0] gs;
    logic ben, brst;
    gs = (m_phase == "idle") ? 2'd0 : (m_phase == "p1win") ? 2'd2 : (m_phase == "p2win") ? 2'd3 : 2'd1;
    ben  = (m_phase == "play");
    brst = !(m_phase == "play" || m_phase == "paused");
    return {gs, 4'(m_p1), 4'(m_p2), ben, brst, 1'(m_dir)};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {game_state, score1, score2, ball_enable, ball_reset, serve_dir};
  endfunction

  task automatic cyc(input logic st, input logic tk, input logic ml, input logic mr, input logic ps);
    start = st; tick_1ms = tk; miss_left = ml; miss_right = mr; pause = ps;
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic tick_n(input int n, input logic st);
    for (int i = 0; i < n; i++) begin
      cyc(st, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(st, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    total++;
    if (dut_vec() !== 13'b00_0000_0000_0_1_1) begin
      bad++; $display("FAIL reset_values: got %h want %h", dut_vec(), 13'b00_0000_0000_0_1_1);
    end
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0);
    total++;
    if (dut_vec() !== model_vec()) begin
      bad++; $display("FAIL after_reset: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_serve();
    cyc(1, 0, 0, 0, 0);
    total++;
    if (game_state !== 2'b01 || ball_enable !== 1'b0 || ball_reset !== 1'b1) begin
      bad++; $display("FAIL serve_entry: got gs=%b ben=%b brst=%b want 01 0 1", game_state, ball_enable, ball_reset);
    end
    cyc(0, 0, 0, 0, 0);
    for (int k = 1; k <= SD; k++) begin
      cyc(0, 1, 0, 0, 0);
      total++;
      if (ball_enable !== ((k == SD) ? 1'b1 : 1'b0) || dut_vec() !== model_vec()) begin
        bad++; $display("FAIL serve_tick%0d: got ben=%b vec=%h want ben=%b vec=%h", k, ball_enable, dut_vec(), (k == SD), model_vec());
      end
      cyc(0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_scoring();
    cyc(0, 0, 0, 1, 0);
    total++;
    if (score1 !== 4'd1 || game_state !== 2'b01 || serve_dir !== 1'b1 || ball_reset !== 1'b1) begin
      bad++; $display("FAIL miss_right: got s1=%0d gs=%b dir=%b brst=%b want 1 01 1 1", score1, game_state, serve_dir, ball_reset);
    end
    tick_n(SD, 1'b0);
    total++;
    if (ball_enable !== 1'b1) begin
      bad++; $display("FAIL replay: got ben=%b want 1", ball_enable);
    end
    cyc(0, 0, 1, 0, 0);
    total++;
    if (score2 !== 4'd1 || serve_dir !== 1'b0 || dut_vec() !== model_vec()) begin
      bad++; $display("FAIL miss_left: got s2=%0d dir=%b vec=%h want 1 0 %h", score2, serve_dir, dut_vec(), model_vec());
    end
  endtask

  task automatic test_win_and_restart();
    tick_n(SD, 1'b0);
    cyc(0, 0, 1, 1, 0);
    total++;
    if (score2 !== 4'd2 || score1 !== 4'd1 || game_state !== 2'b11) begin
      bad++; $display("FAIL double_miss: got s1=%0d s2=%0d gs=%b want 1 2 11", score1, score2, game_state);
    end
    tick_n(WH - 1, 1'b1);
    total++;
    if (game_state !== 2'b11) begin
      bad++; $display("FAIL win_hold: got gs=%b want 11", game_state);
    end
    tick_n(1, 1'b1);
    total++;
    if (game_state !== 2'b00 || score1 !== 4'd1 || score2 !== 4'd2) begin
      bad++; $display("FAIL win_exit: got gs=%b s1=%0d s2=%0d want 00 1 2", game_state, score1, score2);
    end
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
    total++;
    if (game_state !== 2'b00) begin
      bad++; $display("FAIL start_held: got gs=%b want 00", game_state);
    end
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    total++;
    if (game_state !== 2'b01 || score1 !== 4'd0 || score2 !== 4'd0 || serve_dir !== 1'b1) begin
      bad++; $display("FAIL restart: got gs=%b s=%0d/%0d dir=%b want 01 0/0 1", game_state, score1, score2, serve_dir);
    end
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_serve();
    tick_n(2, 1'b0);
    cyc(0, 0, 1, 1, 0);
    total++;
    if (score1 !== 4'd0 || score2 !== 4'd0 || game_state !== 2'b01) begin
      bad++; $display("FAIL miss_in_serve: got s=%0d/%0d gs=%b want 0/0 01", score1, score2, game_state);
    end
    reset = 1'b0;
    cyc(0, 1, 0, 0, 0);
    reset = 1'b1;
    total++;
    if (dut_vec() !== 13'b00_0000_0000_0_1_1) begin
      bad++; $display("FAIL mid_reset: got %h want %h", dut_vec(), 13'b00_0000_0000_0_1_1);
    end
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    tick_n(SD - 1, 1'b0);
    total++;
    if (ball_enable !== 1'b0 || game_state !== 2'b01) begin
      bad++; $display("FAIL full_serve_early: got ben=%b gs=%b want 0 01", ball_enable, game_state);
    end
    tick_n(1, 1'b0);
    total++;
    if (ball_enable !== 1'b1 || dut_vec() !== model_vec()) begin
      bad++; $display("FAIL full_serve_end: got ben=%b vec=%h want 1 %h", ball_enable, dut_vec(), model_vec());
    end
  endtask

`ifdef PONG_PAUSE_EN
  task automatic test_pause();
    cyc(0, 0, 0, 0, 1);
    total++;
    if (ball_enable !== 1'b0 || ball_reset !== 1'b0 || game_state !== 2'b01) begin
      bad++; $display("FAIL pause_enter: got ben=%b brst=%b gs=%b want 0 0 01", ball_enable, ball_reset, game_state);
    end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    total++;
    if (score1 !== 4'd0 || ball_enable !== 1'b0) begin
      bad++; $display("FAIL pause_miss: got s1=%0d ben=%b want 0 0", score1, ball_enable);
    end
    cyc(0, 0, 0, 0, 1);
    total++;
    if (ball_enable !== 1'b1 || dut_vec() !== model_vec()) begin
      bad++; $display("FAIL pause_exit: got ben=%b vec=%h want 1 %h", ball_enable, dut_vec(), model_vec());
    end
    cyc(0, 0, 0, 0, 0);
  endtask
`endif

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 199) != 0);
      cyc(($urandom_range(0, 9) < 3), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 19) == 0));
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        if (errs < 10) $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec(), model_vec());
        errs++;
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_serve();
    test_scoring();
    test_win_and_restart();
    test_reset_mid_serve();
`ifdef PONG_PAUSE_EN
    test_pause();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
